// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR MAC sequencer slice.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fir_seq_state_t;

  localparam int FIR_DEF_TAPS     = 16;
  localparam int FIR_DEF_PIPE_LAT = 2;

  // Address width for a tap count; never narrower than one bit.
  function automatic int fir_addr_width(input int taps);
    if (taps <= 2) begin
      return 1;
    end else begin
      return $clog2(taps);
    end
  endfunction

endpackage

// File: rtl/fir_seq_delay_line.sv
// PIPE_LAT-deep 1-bit shift register aligning acc_en with the product
// emerging from the MAC pipeline; pass-through when PIPE_LAT is zero.
module fir_seq_delay_line #(
  parameter int PIPE_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (PIPE_LAT == 0) begin : g_bypass
      assign q = d;
    end else begin : g_shift
      logic [PIPE_LAT-1:0] sr_r;

      // Shift the address-valid flag one stage per clock.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_r <= {PIPE_LAT{1'b0}};
        end else begin
          sr_r[0] <= d;
          for (int i = 1; i < PIPE_LAT; i++) begin
            sr_r[i] <= sr_r[i-1];
          end
        end
      end

      assign q = sr_r[PIPE_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one shared MAC datapath across all FIR taps per input sample.
// Optional feature macro: FIR_SEQ_BACKPRESSURE_EN (DONE waits for out_ready).
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS       = FIR_DEF_TAPS,
  parameter int ADDR_WIDTH = fir_addr_width(TAPS),
  parameter int PIPE_LAT   = FIR_DEF_PIPE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_addr,
  output logic [ADDR_WIDTH-1:0] coef_addr,
  output logic                  acc_clr,
  output logic                  acc_en,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = ADDR_WIDTH'(32'd0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(32'd1);
  localparam logic [ADDR_WIDTH-1:0] LAST_K     = ADDR_WIDTH'(TAPS - 1);
  localparam logic [2:0]            DRAIN_LAST = 3'((PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0);

  fir_seq_state_t        state_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] k_r;
  logic [ADDR_WIDTH-1:0] buf_addr_r;
  logic [ADDR_WIDTH-1:0] coef_addr_r;
  logic [2:0]            drain_cnt_r;
  logic                  addr_valid_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
  logic                  busy_r;
  logic                  accept_s;
  logic                  done_exit_s;

  // in_ready_r is only ever high in IDLE, so it alone qualifies the accept.
  assign accept_s = in_valid & in_ready_r;

`ifdef FIR_SEQ_BACKPRESSURE_EN
  assign done_exit_s = out_ready;
`else
  logic unused_out_ready_s;
  assign unused_out_ready_s = out_ready;
  assign done_exit_s        = 1'b1;
`endif

  // Control FSM with registered handshake, status and address outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      wr_ptr_r     <= ADDR_ZERO;
      k_r          <= ADDR_ZERO;
      buf_addr_r   <= ADDR_ZERO;
      coef_addr_r  <= ADDR_ZERO;
      drain_cnt_r  <= 3'd0;
      addr_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            state_r      <= CALC;
            k_r          <= ADDR_ZERO;
            coef_addr_r  <= ADDR_ZERO;
            buf_addr_r   <= wr_ptr_r;
            addr_valid_r <= 1'b1;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b1;
          end else begin
            in_ready_r   <= 1'b1;
            busy_r       <= 1'b0;
          end
        end
        CALC: begin
          if (k_r == LAST_K) begin
            addr_valid_r <= 1'b0;
            if (PIPE_LAT == 0) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= DRAIN;
              drain_cnt_r <= 3'd0;
            end
          end else begin
            k_r         <= k_r + ADDR_ONE;
            coef_addr_r <= k_r + ADDR_ONE;
            // Walk backwards from the newest sample through the circular line.
            buf_addr_r  <= wr_ptr_r - k_r - ADDR_ONE;
          end
        end
        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            drain_cnt_r <= drain_cnt_r + 3'd1;
          end
        end
        DONE: begin
          if (done_exit_s) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            wr_ptr_r    <= wr_ptr_r + ADDR_ONE;
            buf_addr_r  <= wr_ptr_r + ADDR_ONE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= IDLE;
          addr_valid_r <= 1'b0;
          in_ready_r   <= 1'b0;
          out_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  fir_seq_delay_line #(
    .PIPE_LAT (PIPE_LAT)
  ) u_acc_en_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (addr_valid_r),
    .q     (acc_en)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign buf_addr  = buf_addr_r;
  assign coef_addr = coef_addr_r;
  assign buf_wr_en = accept_s;
  assign acc_clr   = accept_s;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench: TAPS=4/PIPE_LAT=2 instance with randomized traffic,
// plus a TAPS=2/PIPE_LAT=0 instance for the no-drain corner.
module tb_fir_mac_sequencer;

  localparam int AT = 4;
  localparam int AP = 2;
  localparam int BT = 2;
  localparam int BP = 0;

  logic clk = 1'b0;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic       a_buf_wr_en, a_acc_clr, a_acc_en, a_busy;
  logic [1:0] a_buf_addr, a_coef_addr;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic       b_buf_wr_en, b_acc_clr, b_acc_en, b_busy;
  logic [0:0] b_buf_addr, b_coef_addr;

  int pass_cnt = 0;
  int total_cnt = 0;
  int w_model = 0;

  always #5 clk = ~clk;

  fir_mac_sequencer #(.TAPS(AT), .ADDR_WIDTH(2), .PIPE_LAT(AP)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .buf_wr_en(a_buf_wr_en),
    .buf_addr(a_buf_addr), .coef_addr(a_coef_addr), .acc_clr(a_acc_clr),
    .acc_en(a_acc_en), .busy(a_busy)
  );

  fir_mac_sequencer #(.TAPS(BT), .ADDR_WIDTH(1), .PIPE_LAT(BP)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .buf_wr_en(b_buf_wr_en),
    .buf_addr(b_buf_addr), .coef_addr(b_coef_addr), .acc_clr(b_acc_clr),
    .acc_en(b_acc_en), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One sample on DUT A; cycle c counts from the accept cycle (c=0).
  task automatic do_sample(input bit hold_valid, input int gap, input int hold_done);
    int accs;
    int last;
    last = AT + AP + 1;
    accs = 0;
    step();
    for (int g = 0; g < gap; g++) begin
      a_in_valid  = 1'b0;
      a_out_ready = 1'($urandom);
      #1;
      check("idle_ready", a_in_ready, 1);
      check("idle_wr", a_buf_wr_en, 0);
      check("idle_busy", a_busy, 0);
      step();
    end
    a_in_valid = 1'b1;
    #1;
    check("acc_ready", a_in_ready, 1);
    check("acc_wr", a_buf_wr_en, 1);
    check("acc_clr", a_acc_clr, 1);
    check("acc_wraddr", a_buf_addr, w_model);
    check("acc_ov", a_out_valid, 0);
    for (int c = 1; c <= last; c++) begin
      step();
      a_in_valid = hold_valid ? 1'b1 : 1'($urandom);
`ifdef FIR_SEQ_BACKPRESSURE_EN
      a_out_ready = (c == last) ? (hold_done == 0) : 1'($urandom);
`else
      a_out_ready = 1'($urandom);
`endif
      #1;
      check("run_ready", a_in_ready, 0);
      check("run_wr", a_buf_wr_en, 0);
      check("run_clr", a_acc_clr, 0);
      check("run_busy", a_busy, 1);
      check("run_acc_en", a_acc_en, (c >= AP + 1 && c <= AT + AP) ? 1 : 0);
      check("run_ov", a_out_valid, (c == last) ? 1 : 0);
      if (c <= AT) begin
        check("coef_addr", a_coef_addr, c - 1);
        check("buf_addr", a_buf_addr, (w_model - (c - 1) + AT) % AT);
      end
      if (a_acc_en) accs++;
    end
`ifdef FIR_SEQ_BACKPRESSURE_EN
    for (int j = 1; j <= hold_done; j++) begin
      step();
      a_out_ready = (j == hold_done);
      a_in_valid  = 1'($urandom);
      #1;
      check("hold_ov", a_out_valid, 1);
      check("hold_ready", a_in_ready, 0);
      check("hold_wr", a_buf_wr_en, 0);
    end
`endif
    check("acc_en_count", accs, AT);
    w_model = (w_model + 1) % AT;
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    #3;
    check("rst_ready", a_in_ready, 0);
    check("rst_ov", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_acc_en", a_acc_en, 0);
    check("rst_wr", a_buf_wr_en, 0);
    check("rst_clr", a_acc_clr, 0);
    a_in_valid = 1'b0;
    #19 rst_n = 1'b1;

    // Five back-to-back samples: write addresses 0,1,2,3,0.
    do_sample(1'b0, 0, 0);
    do_sample(1'b1, 0, 10);
    do_sample(1'b0, 0, 0);
    do_sample(1'b1, 0, 3);
    do_sample(1'b0, 0, 1);

    for (int n = 0; n < 6; n++) begin
      do_sample(1'($urandom), int'($urandom_range(3, 0)), int'($urandom_range(6, 0)));
    end

    // Reset mid-CALC at k=2.
    step();
    a_in_valid = 1'b1;
    #1;
    check("mid_acc", a_buf_wr_en, 1);
    for (int c = 1; c <= 3; c++) step();
    check("mid_k2_coef", a_coef_addr, 2);
    rst_n = 1'b0;
    #1;
    check("mr_ready", a_in_ready, 0);
    check("mr_busy", a_busy, 0);
    check("mr_ov", a_out_valid, 0);
    check("mr_acc_en", a_acc_en, 0);
    check("mr_wr", a_buf_wr_en, 0);
    check("mr_clr", a_acc_clr, 0);
    step();
    check("mr_hold_ready", a_in_ready, 0);
    check("mr_hold_acc_en", a_acc_en, 0);
    #2 rst_n = 1'b1;
    w_model = 0;
    do_sample(1'b1, 0, 0);
    do_sample(1'b0, 1, 0);

    // DUT B: TAPS=2, PIPE_LAT=0, no DRAIN.
    a_in_valid = 1'b0;
    step();
    b_in_valid = 1'b1;
    #1;
    check("b_acc_ready", b_in_ready, 1);
    check("b_acc_wr", b_buf_wr_en, 1);
    check("b_acc_clr", b_acc_clr, 1);
    check("b_acc_wraddr", b_buf_addr, 0);
    for (int c = 1; c <= BT + 1; c++) begin
      step();
      #1;
      check("b_ready", b_in_ready, 0);
      check("b_wr", b_buf_wr_en, 0);
      check("b_acc_en", b_acc_en, (c <= BT) ? 1 : 0);
      check("b_ov", b_out_valid, (c == BT + 1) ? 1 : 0);
      check("b_busy", b_busy, 1);
      if (c <= BT) begin
        check("b_coef", b_coef_addr, c - 1);
        check("b_buf", b_buf_addr, (BT - (c - 1)) % BT);
      end
    end
    step();
    b_in_valid = 1'b0;
    #1;
    check("b_back_ready", b_in_ready, 1);
    check("b_back_ov", b_out_valid, 0);
    check("b_next_wraddr", b_buf_addr, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
